regfile_write_arbiter: RTL

//  Writer side of the register file interface: sole driver of WEN/wsel/wdat.

---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback, reservation and hazard-query bundle for the register file writer
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          a_valid;
    logic          a_ready;
    logic [4:0]    a_sel;
    logic [31:0]   a_dat;
    logic          b_valid;
    logic          b_ready;
    logic [4:0]    b_sel;
    logic [31:0]   b_dat;
    logic          rsv_en;
    logic [4:0]    rsv_sel;
    logic [4:0]    q_sel1;
    logic [4:0]    q_sel2;
    logic          q_busy1;
    logic          q_busy2;
    logic          WEN;
    logic [4:0]    wsel;
    logic [31:0]   wdat;
    logic [CW-1:0] b_count;

    modport master (
        output a_valid, a_sel, a_dat, b_valid, b_sel, b_dat,
               rsv_en, rsv_sel, q_sel1, q_sel2,
        input  a_ready, b_ready, q_busy1, q_busy2, WEN, wsel, wdat, b_count
    );

    modport slave (
        input  a_valid, a_sel, a_dat, b_valid, b_sel, b_dat,
               rsv_en, rsv_sel, q_sel1, q_sel2,
        output a_ready, b_ready, q_busy1, q_busy2, WEN, wsel, wdat, b_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges ALU and long-latency writebacks into one register file write per cycle
module regfile_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    regfile_write_arbiter_if.slave  wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic [31:0]   busy;
    logic [31:0]   busy_n;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          force_b;
    logic          take_a;
    logic          win;
    logic [4:0]    win_sel;
    logic [31:0]   win_dat;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_C);
        force_b    = (starve == STARVE_LIM) && !fifo_empty;
        take_a     = wb.a_valid && !force_b;
        pop        = !fifo_empty && (force_b || !wb.a_valid);
        push       = wb.b_valid && !fifo_full;
        win        = take_a || pop;
        if (take_a) begin
            win_sel = wb.a_sel;
            win_dat = wb.a_dat;
        end else begin
            win_sel = mem[rd_ptr][36:32];
            win_dat = mem[rd_ptr][31:0];
        end

        // The clear tracks the write being registered this edge; a same-edge
        // reservation of that register belongs to a newer producer, so it wins.
        busy_n = busy;
        if (win && (win_sel != 5'd0))
            busy_n[win_sel] = 1'b0;
        if (wb.rsv_en && (wb.rsv_sel != 5'd0))
            busy_n[wb.rsv_sel] = 1'b1;
    end

    assign wb.a_ready = !force_b;
    assign wb.b_ready = !fifo_full;
    assign wb.q_busy1 = busy[wb.q_sel1];
    assign wb.q_busy2 = busy[wb.q_sel2];
    assign wb.b_count = count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {wb.b_sel, wb.b_dat};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            starve  <= '0;
            busy    <= '0;
            wb.WEN  <= 1'b0;
            wb.wsel <= '0;
            wb.wdat <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop || fifo_empty)
                starve <= '0;
            else if (take_a)
                starve <= starve + 1'b1;

            busy   <= busy_n;
            wb.WEN <= win && (win_sel != 5'd0);
            if (win) begin
                wb.wsel <= win_sel;
                wb.wdat <= win_dat;
            end
        end
    end
endmodule
